pipe_latch_fall: RTL and testbench

Parametrised elastic pipeline latch for the processor datapath, clocked on the falling edge like the existing single-bit enable flops. It holds DEPTH stages of WIDTH-bit data with per-stage valid bits and a valid/ready handshake on both ends. Bubbles collapse, and a synchronous flush squashes all stages. It replaces hand-chained banks of single-bit flops between pipeline stages and at the plotter command interface.

---
 rtl/pipe_latch_fall_pkg.sv | 20 ++
 rtl/pipe_latch_fall_if.sv | 65 ++++++
 rtl/pipe_latch_fall_stage.sv | 46 ++++
 rtl/pipe_latch_fall.sv | 107 ++++++++++
 tb/tb_pipe_latch_fall.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_latch_fall_pkg.sv
// Shared types and helpers for the falling-edge elastic pipeline latch.
// Optional parity storage: define PIPE_LATCH_FALL_PARITY_EN.
package pipe_latch_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 2;

  function automatic int unsigned clog2p1(input int unsigned d);
    return $clog2(d + 1);
  endfunction

  typedef struct packed {
    logic                 valid;
`ifdef PIPE_LATCH_FALL_PARITY_EN
    logic                 par;
`endif
    logic [DEF_WIDTH-1:0] data;
  } stage_t;

endpackage

// File: rtl/pipe_latch_fall_if.sv
// Valid/ready bus for pipe_latch_fall: upstream and downstream handshakes.
// parity_err exists only with PIPE_LATCH_FALL_PARITY_EN defined.
interface pipe_latch_fall_if
  import pipe_latch_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) ();

  localparam int unsigned OW = clog2p1(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OW-1:0]    occupancy;
`ifdef PIPE_LATCH_FALL_PARITY_EN
  logic             parity_err;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy,
    input  parity_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy,
    output parity_err
  );
`else
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );
`endif

endinterface

// File: rtl/pipe_latch_fall_stage.sv
// One falling-edge stage: valid, data and (optional) parity register.
// Parity register present with PIPE_LATCH_FALL_PARITY_EN defined.
module pipe_latch_stage #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             en,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
`ifdef PIPE_LATCH_FALL_PARITY_EN
  input  logic             up_par,
  output logic             par,
`endif
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Data only loads on a real word so bubbles never overwrite it.
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

`ifdef PIPE_LATCH_FALL_PARITY_EN
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      par <= 1'b0;
    end else if (!flush && en && up_valid) begin
      par <= up_par;
    end
  end
`endif

endmodule

// File: rtl/pipe_latch_fall.sv
// Elastic DEPTH-stage falling-edge pipeline latch with collapsing bubbles.
// Optional even parity per stage: define PIPE_LATCH_FALL_PARITY_EN.
module pipe_latch_fall
  import pipe_latch_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic clk,
  input  logic clr,
  input  logic flush,
  pipe_latch_fall_if.slave bus
);

  localparam int unsigned OW = clog2p1(DEPTH);

  logic [DEPTH:0]            rdy;
  logic [DEPTH-1:0]          vld;
  logic [DEPTH-1:0]          nv;
  logic [DEPTH-1:0][WIDTH-1:0] dat;
  logic [OW-1:0]             cnt;
  logic [OW-1:0]             occ;
`ifdef PIPE_LATCH_FALL_PARITY_EN
  logic [DEPTH-1:0]          par;
  logic                      perr;
`endif

  assign rdy[DEPTH] = bus.out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_st
    logic             upv;
    logic [WIDTH-1:0] upd;
`ifdef PIPE_LATCH_FALL_PARITY_EN
    logic             upp;
`endif

    if (g == 0) begin : g_in
      assign upv = bus.in_valid;
      assign upd = bus.in_data;
`ifdef PIPE_LATCH_FALL_PARITY_EN
      assign upp = ^bus.in_data;
`endif
    end else begin : g_mid
      assign upv = vld[g-1];
      assign upd = dat[g-1];
`ifdef PIPE_LATCH_FALL_PARITY_EN
      assign upp = par[g-1];
`endif
    end

    // A stage moves when it is empty or the stage ahead moves.
    assign rdy[g] = ~vld[g] | rdy[g+1];
    assign nv[g]  = flush ? 1'b0 : (rdy[g] ? upv : vld[g]);

    pipe_latch_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_st (
      .clk      (clk),
      .clr      (clr),
      .flush    (flush),
      .en       (rdy[g]),
      .up_valid (upv),
      .up_data  (upd),
`ifdef PIPE_LATCH_FALL_PARITY_EN
      .up_par   (upp),
      .par      (par[g]),
`endif
      .valid    (vld[g]),
      .data     (dat[g])
    );
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + OW'(nv[i]);
    end
  end

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      occ <= '0;
    end else begin
      occ <= cnt;
    end
  end

  assign bus.in_ready  = rdy[0] & ~flush;
  assign bus.out_valid = vld[DEPTH-1];
  assign bus.out_data  = dat[DEPTH-1];
  assign bus.occupancy = occ;

`ifdef PIPE_LATCH_FALL_PARITY_EN
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      perr <= 1'b0;
    end else begin
      perr <= vld[DEPTH-1] & ((^dat[DEPTH-1]) != par[DEPTH-1]);
    end
  end

  assign bus.parity_err = perr;
`endif

endmodule

// File: tb/tb_pipe_latch_fall.sv
// Self-checking bench for pipe_latch_fall: directed and random traffic
// against a queue model of word positions.
module tb_pipe_latch_fall;

  localparam int unsigned D2 = 2;
  localparam int unsigned D4 = 4;
  localparam logic [31:0] RV = 32'h1234_5678;

  logic clk = 1'b1;
  logic clr;
  logic flush2;
  logic flush4;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_latch_fall_if #(.WIDTH(32), .DEPTH(D2)) b2 ();
  pipe_latch_fall_if #(.WIDTH(32), .DEPTH(D4)) b4 ();

  pipe_latch_fall #(
    .WIDTH(32), .DEPTH(D2), .RESET_VAL(RV)
  ) u2 (
    .clk(clk), .clr(clr), .flush(flush2), .bus(b2)
  );

  pipe_latch_fall #(
    .WIDTH(32), .DEPTH(D4), .RESET_VAL(RV)
  ) u4 (
    .clk(clk), .clr(clr), .flush(flush4), .bus(b4)
  );

  // Model: each queued word knows which stage it sits in (head = oldest).
  int          mpos[$];
  logic [31:0] mdat[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit m_ready(input bit ordy, input bit fl);
    return !fl && (mpos.size() < D2 || ordy);
  endfunction

  function automatic bit m_ovalid();
    return mpos.size() > 0 && mpos[0] == D2 - 1;
  endfunction

  task automatic m_step(input bit iv, input logic [31:0] id,
                        input bit ordy, input bit fl);
    bit acc;
    acc = iv && m_ready(ordy, fl);
    if (fl) begin
      mpos.delete();
      mdat.delete();
    end else begin
      if (m_ovalid() && ordy) begin
        void'(mpos.pop_front());
        void'(mdat.pop_front());
      end
      foreach (mpos[k]) begin
        if (mpos[k] + 1 < D2 && (k == 0 || mpos[k-1] != mpos[k] + 1))
          mpos[k] = mpos[k] + 1;
      end
      if (acc) begin
        mpos.push_back(0);
        mdat.push_back(id);
      end
    end
  endtask

  // Called just after a rising edge; the falling edge lies inside.
  task automatic cyc(input bit iv, input logic [31:0] id,
                     input bit ordy, input bit fl);
    b2.in_valid  = iv;
    b2.in_data   = id;
    b2.out_ready = ordy;
    flush2       = fl;
    #1;
    chk("in_ready", {31'd0, b2.in_ready}, {31'd0, m_ready(ordy, fl)});
    m_step(iv, id, ordy, fl);
    @(posedge clk);
    chk("out_valid", {31'd0, b2.out_valid}, {31'd0, m_ovalid()});
    if (m_ovalid()) chk("out_data", b2.out_data, mdat[0]);
    chk("occupancy", {30'd0, b2.occupancy}, mpos.size());
  endtask

  initial begin
    clr          = 1'b0;
    flush2       = 1'b0;
    flush4       = 1'b0;
    b2.in_valid  = 1'b1;
    b2.in_data   = 32'hDEAD_BEEF;
    b2.out_ready = 1'b0;
    b4.in_valid  = 1'b0;
    b4.in_data   = '0;
    b4.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    chk("rst_out_valid", {31'd0, b2.out_valid}, 32'd0);
    chk("rst_occupancy", {30'd0, b2.occupancy}, 32'd0);
    chk("rst_out_data", b2.out_data, RV);
    chk("rst_in_ready", {31'd0, b2.in_ready}, 32'd1);
    chk("rst4_out_data", b4.out_data, RV);

    clr = 1'b1;

    // Latency: pulse in, out after two falling edges, then gone.
    cyc(1'b1, 32'h0000_00A5, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("lat_valid", {31'd0, b2.out_valid}, 32'd1);
    chk("lat_data", b2.out_data, 32'h0000_00A5);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("lat_drop", {31'd0, b2.out_valid}, 32'd0);

    // Backpressure: 1,2 fill, 3 stalls, then drain in order.
    cyc(1'b1, 32'd1, 1'b0, 1'b0);
    cyc(1'b1, 32'd2, 1'b0, 1'b0);
    chk("bp_occ", {30'd0, b2.occupancy}, 32'd2);
    cyc(1'b1, 32'd3, 1'b0, 1'b0);
    chk("bp_head", b2.out_data, 32'd1);
    cyc(1'b1, 32'd3, 1'b1, 1'b0);
    chk("bp_second", b2.out_data, 32'd2);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("bp_third", b2.out_data, 32'd3);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush a full pipe with a word offered; next edge accepts.
    cyc(1'b1, 32'd10, 1'b0, 1'b0);
    cyc(1'b1, 32'd11, 1'b0, 1'b0);
    cyc(1'b1, 32'd12, 1'b1, 1'b1);
    chk("fl_occ", {30'd0, b2.occupancy}, 32'd0);
    chk("fl_valid", {31'd0, b2.out_valid}, 32'd0);
    cyc(1'b1, 32'd13, 1'b1, 1'b0);
    chk("fl_accept", {30'd0, b2.occupancy}, 32'd1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("fl_out", b2.out_data, 32'd13);

    // Random traffic with occasional flush.
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 9) < 7, $urandom,
          $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

`ifdef PIPE_LATCH_FALL_PARITY_EN
    cyc(1'b1, 32'h0000_0055, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("par_clean", {31'd0, b2.parity_err}, 32'd0);
    force u2.g_st[1].u_st.data = 32'h0000_0054;
    @(posedge clk);
    chk("par_err", {31'd0, b2.parity_err}, 32'd1);
    release u2.g_st[1].u_st.data;
    b2.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    chk("par_clear", {31'd0, b2.parity_err}, 32'd0);
    mpos.delete();
    mdat.delete();
`endif

    // Bubble collapse on the 4-deep latch: A, idle, B with no drain.
    b4.in_valid = 1'b1;
    b4.in_data  = 32'h0000_AAAA;
    @(posedge clk);
    b4.in_valid = 1'b0;
    @(posedge clk);
    b4.in_valid = 1'b1;
    b4.in_data  = 32'h0000_BBBB;
    @(posedge clk);
    b4.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    chk("bub_occ", {29'd0, b4.occupancy}, 32'd2);
    chk("bub_valid", {31'd0, b4.out_valid}, 32'd1);
    chk("bub_head", b4.out_data, 32'h0000_AAAA);
    chk("bub_ready", {31'd0, b4.in_ready}, 32'd1);
    b4.out_ready = 1'b1;
    @(posedge clk);
    chk("bub_next", b4.out_data, 32'h0000_BBBB);
    chk("bub_occ1", {29'd0, b4.occupancy}, 32'd1);
    @(posedge clk);
    chk("bub_empty", {31'd0, b4.out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
